// File: rtl/snake_sprite_fetch_if.sv
// Pixel/sprite bus between the scan generator, the sprite fetch stage and its ROM.
// The master side drives scan/sprite requests and ROM data; the slave side is the fetch stage.
interface snake_sprite_fetch_if #(
   parameter int ADDR_W = 13
);
   logic              frame_start;
   logic              anim_en;
   logic              pixel_valid;
   logic [9:0]        DrawX;
   logic [9:0]        DrawY;
   logic [9:0]        SpriteX;
   logic [9:0]        SpriteY;
   logic [1:0]        dir_in;
   logic [ADDR_W-1:0] rom_addr;
   logic [3:0]        rom_q;
   logic [3:0]        index;
   logic              hit;
   logic              out_valid;

   modport master (
      output frame_start, anim_en, pixel_valid, DrawX, DrawY, SpriteX, SpriteY, dir_in, rom_q,
      input  rom_addr, index, hit, out_valid
   );

   modport slave (
      input  frame_start, anim_en, pixel_valid, DrawX, DrawY, SpriteX, SpriteY, dir_in, rom_q,
      output rom_addr, index, hit, out_valid
   );
endinterface

// File: rtl/snake_sprite_fetch.sv
// Snake head sprite fetch: box test, ROM address generation and hit/index alignment,
// with per-frame latching of direction/position and a frame-based animation counter.
module snake_sprite_fetch #(
   parameter int SPR_W       = 32,
   parameter int SPR_H       = 32,
   parameter int ANIM_FRAMES = 2,
   parameter int ANIM_PERIOD = 8,
   parameter int ROM_LAT     = 1,
   parameter int ADDR_W      = 13
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   snake_sprite_fetch_if.slave  bus
);
   localparam int CNT_W  = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
   localparam int ANIM_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

   logic [1:0]        r_dir_cur;
   logic [9:0]        r_posx_cur;
   logic [9:0]        r_posy_cur;
   logic [CNT_W-1:0]  r_frame_cnt;
   logic [ANIM_W-1:0] r_anim_idx;

   logic [ADDR_W-1:0] r_rom_addr;
   logic              r_v1;
   logic              r_in1;
   logic [ROM_LAT-1:0] r_v_dly;
   logic [ROM_LAT-1:0] r_in_dly;
   logic [3:0]        r_index;
   logic              r_hit;
   logic              r_out_valid;

   logic [10:0]       w_x;
   logic [10:0]       w_y;
   logic [10:0]       w_px;
   logic [10:0]       w_py;
   logic [10:0]       w_dx;
   logic [10:0]       w_dy;
   logic              w_inbox;
   logic [ADDR_W-1:0] w_addr;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_dir_cur   <= '0;
         r_posx_cur  <= '0;
         r_posy_cur  <= '0;
         r_frame_cnt <= '0;
         r_anim_idx  <= '0;
      end else if (bus.frame_start) begin
         r_dir_cur  <= bus.dir_in;
         r_posx_cur <= bus.SpriteX;
         r_posy_cur <= bus.SpriteY;
         if (bus.anim_en) begin
            if (r_frame_cnt == CNT_W'(ANIM_PERIOD - 1)) begin
               r_frame_cnt <= '0;
               // ANIM_FRAMES is a power of two, so the natural wrap of r_anim_idx is the modulo
               if (ANIM_FRAMES > 1)
                  r_anim_idx <= r_anim_idx + 1'b1;
            end else begin
               r_frame_cnt <= r_frame_cnt + 1'b1;
            end
         end
      end
   end

   // Box test at 11 bits so a sprite near column/row 1023 clips instead of wrapping
   assign w_x  = {1'b0, bus.DrawX};
   assign w_y  = {1'b0, bus.DrawY};
   assign w_px = {1'b0, r_posx_cur};
   assign w_py = {1'b0, r_posy_cur};
   assign w_dx = w_x - w_px;
   assign w_dy = w_y - w_py;

   assign w_inbox = bus.pixel_valid
                 && (w_x >= w_px) && (w_x < w_px + 11'(SPR_W))
                 && (w_y >= w_py) && (w_y < w_py + 11'(SPR_H));

   assign w_addr = ADDR_W'(((32'(r_dir_cur) * ANIM_FRAMES + 32'(r_anim_idx)) * SPR_H
                            + 32'(w_dy)) * SPR_W + 32'(w_dx));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rom_addr <= '0;
         r_v1       <= 1'b0;
         r_in1      <= 1'b0;
      end else begin
         if (w_inbox)
            r_rom_addr <= w_addr;
         r_v1  <= bus.pixel_valid;
         r_in1 <= w_inbox;
      end
   end

   // Valid/inbox travel alongside the ROM access so they line up with rom_q
   genvar gi;
   generate
      for (gi = 0; gi < ROM_LAT; gi++) begin : g_dly
         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               r_v_dly[gi]  <= 1'b0;
               r_in_dly[gi] <= 1'b0;
            end else if (gi == 0) begin
               r_v_dly[gi]  <= r_v1;
               r_in_dly[gi] <= r_in1;
            end else begin
               r_v_dly[gi]  <= r_v_dly[(gi == 0) ? 0 : gi - 1];
               r_in_dly[gi] <= r_in_dly[(gi == 0) ? 0 : gi - 1];
            end
         end
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_out_valid <= 1'b0;
         r_index     <= '0;
         r_hit       <= 1'b0;
      end else begin
         r_out_valid <= r_v_dly[ROM_LAT-1];
         // Palette index 0 is the chroma key, so it never produces a hit
         if (r_in_dly[ROM_LAT-1] && (bus.rom_q != 4'd0)) begin
            r_index <= bus.rom_q;
            r_hit   <= 1'b1;
         end else begin
            r_index <= '0;
            r_hit   <= 1'b0;
         end
      end
   end

   assign bus.rom_addr  = r_rom_addr;
   assign bus.index     = r_index;
   assign bus.hit       = r_hit;
   assign bus.out_valid = r_out_valid;
endmodule

// File: doc/snake_sprite_fetch.md
Name: snake_sprite_fetch

Overview:
Per-pixel sprite fetch stage that sits directly upstream of the snake palette lookup.
- From the VGA scan position and the snake head position, decides whether the current pixel lies inside the sprite box.
- Computes the address into the snake sprite ROM, which is selected by direction and animation frame.
- Aligns the returned 4-bit palette index with a hit flag for the palette and colour mux.
- Latches direction and position once per frame so a frame never tears, and runs a frame-based animation counter.

Parameters:
SPR_W, 32, sprite width in pixels (power of 2)
SPR_H, 32, sprite height in pixels (power of 2)
ANIM_FRAMES, 2, animation frames per direction (power of 2, >=1)
ANIM_PERIOD, 8, video frames per animation step (>=1)
ROM_LAT, 1, read latency of the external sprite ROM in cycles (rom_addr to rom_q)
ADDR_W, 13, ROM address width; must equal clog2(4*ANIM_FRAMES*SPR_W*SPR_H)

Ports:
Clk  in  1  pixel clock; the only clock
Reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at the start of vertical blank
anim_en  in  1  when 1, animation advances on frame_start
pixel_valid  in  1  DrawX/DrawY describe an active pixel this cycle
DrawX  in  10  current scan column
DrawY  in  10  current scan row
SpriteX  in  10  requested head sprite left edge
SpriteY  in  10  requested head sprite top edge
dir_in  in  2  requested direction: 0 right, 1 left, 2 up, 3 down
rom_addr  out  ADDR_W  sprite ROM read address
rom_q  in  4  sprite ROM data, ROM_LAT cycles after rom_addr
index  out  4  palette index sent to the palette stage
hit  out  1  pixel belongs to the sprite and is opaque
out_valid  out  1  index/hit correspond to an accepted pixel

Behaviour:
- Reset (synchronous, at the clock edge when Reset=1):
  - dir_cur=0, posX_cur=0, posY_cur=0, frame_cnt=0, anim_idx=0.
  - rom_addr=0, index=0, hit=0, out_valid=0.
  - All internal pipeline valid bits are cleared, so in-flight pixels are dropped.
  - Reset has priority over every other event.
- Frame latch: on frame_start=1, dir_cur<=dir_in, posX_cur<=SpriteX, posY_cur<=SpriteY.
  - A pixel sampled in the same cycle uses the old latched values.
  - New values apply from the next cycle.
- Animation counter, on frame_start with anim_en=1:
  - If frame_cnt==ANIM_PERIOD-1: frame_cnt<=0 and anim_idx<=(anim_idx+1) mod ANIM_FRAMES.
  - Otherwise frame_cnt<=frame_cnt+1.
  - With anim_en=0, both counters hold.
  - ANIM_PERIOD=1 means anim_idx advances every frame.
- Stage 1 (edge after sampling):
  - dx=DrawX-posX_cur and dy=DrawY-posY_cur, computed at 11 bits.
  - inbox = pixel_valid and DrawX>=posX_cur and DrawX<posX_cur+SPR_W and DrawY>=posY_cur and DrawY<posY_cur+SPR_H.
  - The sums are 11-bit, so a sprite near coordinate 1023 never wraps and clips correctly.
  - rom_addr <= ((dir_cur*ANIM_FRAMES+anim_idx)*SPR_H+dy)*SPR_W+dx when inbox=1; otherwise rom_addr holds its value.
  - v1<=pixel_valid, in1<=inbox.
- Delay: v1 and in1 are delayed ROM_LAT cycles so they align with rom_q.
- Output stage (registered):
  - out_valid<=aligned v.
  - If aligned inbox=1 and rom_q!=0: index<=rom_q, hit<=1.
  - Otherwise index<=0 and hit<=0. Index 0 is the chroma-key, transparent.
- Latency: a pixel sampled at edge t appears on index/hit/out_valid at edge t+2+ROM_LAT (3 with defaults).
- Throughput: one pixel per cycle with no stalls. The pipeline accepts a pixel every cycle regardless of pixel_valid; invalid slots propagate with out_valid=0, hit=0.

Test Plan:
1. Reset asserted for 2 cycles mid-stream, then DrawX/DrawY swept -> out_valid, hit, index are all 0 during reset and for 3 cycles after; rom_addr=0 on the first edge after reset.
2. Latch and address check.
   - Stimulus: SpriteX=100, SpriteY=50, dir_in=0, frame_start pulse; then pixel (DrawX=105, DrawY=52) with the ROM model returning 7.
   - Response: rom_addr=2*32+5=69 one cycle later; index=7, hit=1, out_valid=1 exactly 3 cycles after the pixel.
3. Direction selection with the same position and dir_in=1 latched -> same pixel gives rom_addr=(2*32*32)+69=2117; a pixel at DrawX=132 (outside the box) gives hit=0, index=0.
4. Transparency: in-box pixel where rom_q=0 -> hit=0, index=0, out_valid=1.
5. Animation counter: anim_en=1 with 8 frame_start pulses -> anim_idx=1 and the same pixel's rom_addr rises by 1024; after 16 pulses it wraps to anim_idx=0. With anim_en=0, 8 pulses leave anim_idx unchanged.
6. Edge conditions.
   - frame_start coincident with a pixel while dir_in changes 0->2 -> that pixel uses dir 0 and the next pixel uses dir 2.
   - SpriteX=1000 and DrawX=1023 -> hit possible (dx=23) with no wrap to low columns; DrawX=5 gives hit=0.
